pipe_ex: RTL and testbench

- Execute stage of the 5-stage pipelined MIPS-style CPU.
- Takes decoded operands and control signals from the ID stage and performs the ALU operation combinationally.
- Captures the ALU result, store data and the forwarded write-back/memory controls in the EX/MEM pipeline register.
- Feeds the MEM stage.

---
 rtl/pipe_ex.sv | 97 +++++++++
 tb/tb_pipe_ex.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_ex.sv
// -----------------------------------------------------------------------------
// pipe_ex
//   Execute stage of the 5-stage pipelined MIPS-style CPU. It selects the ALU
//   operands from the decoded ID-stage values and evaluates the ALU
//   combinationally. The EX/MEM pipeline register then captures these values:
//   - the ALU result
//   - the store data
//   - the write-back and memory controls that pass through to the MEM stage
//
// Ports
//   clk          rising-edge clock for the EX/MEM register
//   clrn         asynchronous active-high clear of the EX/MEM register
//   IDwreg       register-file write enable from ID
//   IDm2reg      write-back select from ID (1 = memory data)
//   IDwmem       data-memory write enable from ID
//   IDaluc[3:0]  ALU operation code
//   IDshift      1 = operand A is IDimmeOrSa (shift amount)
//   IDaluimm     1 = operand B is IDimmeOrSa (immediate)
//   IDwn[4:0]    destination register number
//   IDqa[31:0]   register operand A
//   IDqb[31:0]   register operand B / store data
//   IDimmeOrSa   extended immediate or zero-extended shift amount
//   EXwreg, EXm2reg, EXwmem, EXwn   registered control pass-through
//   EXaluResult  registered ALU result
//   EXdi         registered IDqb (store data to memory)
// -----------------------------------------------------------------------------
module pipe_ex (
  input  logic        clk,
  input  logic        clrn,
  input  logic        IDwreg,
  input  logic        IDm2reg,
  input  logic        IDwmem,
  input  logic [3:0]  IDaluc,
  input  logic        IDshift,
  input  logic        IDaluimm,
  input  logic [4:0]  IDwn,
  input  logic [31:0] IDqa,
  input  logic [31:0] IDqb,
  input  logic [31:0] IDimmeOrSa,
  output logic        EXwreg,
  output logic        EXm2reg,
  output logic        EXwmem,
  output logic [4:0]  EXwn,
  output logic [31:0] EXaluResult,
  output logic [31:0] EXdi
);

  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic [31:0] alu_result;

  assign op_a  = IDshift  ? IDimmeOrSa : IDqa;
  assign op_b  = IDaluimm ? IDimmeOrSa : IDqb;
  assign shamt = op_a[4:0];

  // The low two bits of aluc pick the operation family. Bit 2 selects the
  // variant within that family. For shifts, bits 3:2 also choose the shift
  // kind, and code 1011 yields zero.
  always_comb begin
    alu_result = 32'h0;
    unique case (IDaluc[1:0])
      2'b00: alu_result = IDaluc[2] ? (op_a - op_b) : (op_a + op_b);
      2'b01: alu_result = IDaluc[2] ? (op_a | op_b) : (op_a & op_b);
      2'b10: alu_result = IDaluc[2] ? {op_b[15:0], 16'h0000} : (op_a ^ op_b);
      2'b11: begin
        unique case (IDaluc[3:2])
          2'b00: alu_result = op_b << shamt;
          2'b01: alu_result = op_b >> shamt;
          2'b11: alu_result = $unsigned($signed(op_b) >>> shamt);
          2'b10: alu_result = 32'h0;
        endcase
      end
    endcase
  end

  // The EX/MEM register has no stall or flush inputs, so it loads every cycle.
  // Asserting clrn clears it immediately, and any in-flight value is dropped.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      EXwreg      <= 1'b0;
      EXm2reg     <= 1'b0;
      EXwmem      <= 1'b0;
      EXwn        <= 5'd0;
      EXaluResult <= 32'h0;
      EXdi        <= 32'h0;
    end else begin
      EXwreg      <= IDwreg;
      EXm2reg     <= IDm2reg;
      EXwmem      <= IDwmem;
      EXwn        <= IDwn;
      EXaluResult <= alu_result;
      EXdi        <= IDqb;
    end
  end

endmodule

// File: tb/tb_pipe_ex.sv
// -----------------------------------------------------------------------------
// tb_pipe_ex
//   Directed self-checking bench for pipe_ex. Each vector is applied on the
//   falling edge. The EX outputs are then compared 1 ns after the next rising
//   edge against hand-computed values.
// -----------------------------------------------------------------------------
module tb_pipe_ex;

  logic        clk;
  logic        clrn;
  logic        id_wreg;
  logic        id_m2reg;
  logic        id_wmem;
  logic [3:0]  id_aluc;
  logic        id_shift;
  logic        id_aluimm;
  logic [4:0]  id_wn;
  logic [31:0] id_qa;
  logic [31:0] id_qb;
  logic [31:0] id_imm;
  logic        ex_wreg;
  logic        ex_m2reg;
  logic        ex_wmem;
  logic [4:0]  ex_wn;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_di;

  int tests_run;
  int tests_failed;

  pipe_ex dut (
    .clk         (clk),
    .clrn        (clrn),
    .IDwreg      (id_wreg),
    .IDm2reg     (id_m2reg),
    .IDwmem      (id_wmem),
    .IDaluc      (id_aluc),
    .IDshift     (id_shift),
    .IDaluimm    (id_aluimm),
    .IDwn        (id_wn),
    .IDqa        (id_qa),
    .IDqb        (id_qb),
    .IDimmeOrSa  (id_imm),
    .EXwreg      (ex_wreg),
    .EXm2reg     (ex_m2reg),
    .EXwmem      (ex_wmem),
    .EXwn        (ex_wn),
    .EXaluResult (ex_alu_result),
    .EXdi        (ex_di)
  );

  // Clock with a 10 ns period; rising edges fall at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Compares every EX output against the expected values.
  task automatic checkAll(input string tag, input logic [31:0] result,
                          input logic [31:0] di, input logic wreg,
                          input logic m2reg, input logic wmem,
                          input logic [4:0] wn);
    checkOutput({tag, ".result"}, ex_alu_result, result);
    checkOutput({tag, ".di"},     ex_di,         di);
    checkOutput({tag, ".wreg"},   {31'd0, ex_wreg},  {31'd0, wreg});
    checkOutput({tag, ".m2reg"},  {31'd0, ex_m2reg}, {31'd0, m2reg});
    checkOutput({tag, ".wmem"},   {31'd0, ex_wmem},  {31'd0, wmem});
    checkOutput({tag, ".wn"},     {27'd0, ex_wn},    {27'd0, wn});
  endtask

  // Drives one set of ID-stage inputs.
  task automatic applyStimulus(input logic [3:0] aluc, input logic shift,
                               input logic aluimm, input logic [31:0] qa,
                               input logic [31:0] qb, input logic [31:0] imm,
                               input logic wreg, input logic m2reg,
                               input logic wmem, input logic [4:0] wn);
    id_aluc   = aluc;
    id_shift  = shift;
    id_aluimm = aluimm;
    id_qa     = qa;
    id_qb     = qb;
    id_imm    = imm;
    id_wreg   = wreg;
    id_m2reg  = m2reg;
    id_wmem   = wmem;
    id_wn     = wn;
  endtask

  // Applies a vector on the falling edge and samples just after the next
  // rising edge. Only the ALU result and store data are checked here.
  task automatic runAlu(input string tag, input logic [3:0] aluc,
                        input logic shift, input logic aluimm,
                        input logic [31:0] qa, input logic [31:0] qb,
                        input logic [31:0] imm, input logic [31:0] expected);
    @(negedge clk);
    applyStimulus(aluc, shift, aluimm, qa, qb, imm, 1'b0, 1'b0, 1'b0, 5'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, ".result"}, ex_alu_result, expected);
    checkOutput({tag, ".di"},     ex_di,         qb);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    // Reset with nonzero inputs. The outputs must clear immediately and stay
    // clear across a clock edge.
    clrn = 1'b1;
    applyStimulus(4'b0000, 1'b0, 1'b0, 32'd2, 32'd3, 32'd0,
                  1'b1, 1'b1, 1'b1, 5'd9);
    #1;
    checkAll("reset_now", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    @(posedge clk);
    #1;
    checkAll("reset_edge", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);

    // Release reset between edges. The next rising edge loads 2 + 3.
    @(negedge clk);
    clrn = 1'b0;
    #1;
    checkOutput("release_hold", ex_alu_result, 32'h0);
    @(posedge clk);
    #1;
    checkAll("add_2_3", 32'd5, 32'd3, 1'b1, 1'b1, 1'b1, 5'd9);

    runAlu("add_4_7",   4'b0000, 1'b0, 1'b0, 32'd4, 32'd7, 32'd0, 32'd11);
    runAlu("add_wrap",  4'b1000, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0,
           32'h0);
    runAlu("sub",       4'b0100, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0,
           32'hFFFFFFFE);
    runAlu("and",       4'b0001, 1'b0, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00,
           32'd0, 32'hF000F000);
    runAlu("or",        4'b0101, 1'b0, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00,
           32'd0, 32'hFFF0FFF0);
    runAlu("xor",       4'b0010, 1'b0, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00,
           32'd0, 32'h0FF00FF0);
    // Immediate operand; EXdi still carries qb.
    runAlu("addi",      4'b0000, 1'b0, 1'b1, 32'h20, 32'hDEADBEEF, 32'h10,
           32'h30);
    runAlu("lui",       4'b0110, 1'b0, 1'b1, 32'h20, 32'h55, 32'h1234,
           32'h12340000);
    runAlu("sll",       4'b0011, 1'b1, 1'b0, 32'h0, 32'h80000010, 32'd4,
           32'h00000100);
    runAlu("srl",       4'b0111, 1'b1, 1'b0, 32'h0, 32'h80000010, 32'd4,
           32'h08000001);
    runAlu("sra",       4'b1111, 1'b1, 1'b0, 32'h0, 32'h80000010, 32'd4,
           32'hF8000001);
    // Only a[4:0] is used: 0x24 shifts by 4.
    runAlu("srl_upper", 4'b0111, 1'b1, 1'b0, 32'h0, 32'h80000010, 32'h24,
           32'h08000001);
    runAlu("zero_op",   4'b1011, 1'b0, 1'b0, 32'h12345678, 32'h9ABCDEF0,
           32'd0, 32'h0);

    // Control signals pass through with one cycle of latency.
    @(negedge clk);
    applyStimulus(4'b0000, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0,
                  1'b1, 1'b1, 1'b1, 5'd17);
    @(posedge clk);
    #1;
    checkAll("ctrl", 32'd2, 32'd1, 1'b1, 1'b1, 1'b1, 5'd17);

    // Reset asserted mid-cycle clears the outputs at once and keeps them
    // clear across an edge.
    #2;
    clrn = 1'b1;
    #1;
    checkAll("mid_reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    @(posedge clk);
    #1;
    checkAll("mid_reset_edge", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);

    // Loading resumes at the first rising edge after release.
    @(negedge clk);
    clrn = 1'b0;
    @(posedge clk);
    #1;
    checkAll("resume", 32'd2, 32'd1, 1'b1, 1'b1, 1'b1, 5'd17);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
